// File: rtl/msm_loader_if.sv
// msm_loader_if: stream bundle between the pair producer / result consumer
// and msm_loader.
//   Input stream : in_valid, in_ready, in_point ({x, y}, 2x256), in_scalar (256)
//   Result stream: out_valid, out_ready, out_R ({Rx, Ry}, 512)
// master: producer/consumer side; slave: the loader.
interface msm_loader_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_point;
    logic [255:0] in_scalar;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_R;

    modport master (
        output in_valid, in_point, in_scalar, out_ready,
        input  in_ready, out_valid, out_R
    );

    modport slave (
        input  in_valid, in_point, in_scalar, out_ready,
        output in_ready, out_valid, out_R
    );
endinterface

// File: rtl/msm_loader.sv
// msm_loader: feeds (point, scalar) pairs into the G/x operand arrays of an
// msm_naive core, launches the core by releasing its reset, captures R on
// Done and presents it on a valid/ready result port. The next batch may be
// loaded while a captured result is still waiting to be consumed.
// Ports:
//   clk        - single clock, rising edge
//   Reset      - asynchronous, active-low reset
//   s          - msm_loader_if.slave (pair input stream, result output stream)
//   G, x       - registered point / scalar arrays to the core
//   msm_reset  - active-high core reset; low only while the core computes
//   msm_done   - core Done, honoured only in RUN
//   msm_R      - core result {Rx, Ry}
//   busy       - high in KICK and RUN
module msm_loader #(
    parameter int unsigned length = 3
) (
    input  logic                     clk,
    input  logic                     Reset,
    msm_loader_if.slave              s,
    output logic [length-1:0][511:0] G,
    output logic [length-1:0][255:0] x,
    output logic                     msm_reset,
    input  logic                     msm_done,
    input  logic [511:0]             msm_R,
    output logic                     busy
);
    localparam int unsigned CNT_W = (length > 1) ? $clog2(length) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(length - 1);

    typedef enum logic [1:0] {LOAD, KICK, RUN} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      full_q, full_d;
    logic                      out_valid_q, out_valid_d;
    logic [511:0]              out_r_q, out_r_d;
    logic [length-1:0][511:0]  g_q, g_d;
    logic [length-1:0][255:0]  x_q, x_d;
    logic                      msm_reset_q, msm_reset_d;
    logic                      busy_q, busy_d;
    logic                      xfer;

    // in_ready is forced low while Reset is asserted, even though the
    // registers already show LOAD with an empty batch.
    assign s.in_ready  = Reset && (state_q == LOAD) && !full_q;
    assign xfer        = s.in_valid && s.in_ready;

    assign s.out_valid = out_valid_q;
    assign s.out_R     = out_r_q;
    assign G           = g_q;
    assign x           = x_q;
    assign msm_reset   = msm_reset_q;
    assign busy        = busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        g_d         = g_q;
        x_d         = x_q;

        if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            LOAD: begin
                if (xfer) begin
                    for (int i = 0; i < int'(length); i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            g_d[i] = s.in_point;
                            x_d[i] = s.in_scalar;
                        end
                    end
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        full_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                // Looking at next-cycle values lets the last accept, or the
                // consume of a pending result, kick the core on the same edge.
                if (full_d && !out_valid_d) begin
                    state_d = KICK;
                end
            end
            // One cycle with the core still in reset so it samples stable G/x.
            KICK: state_d = RUN;
            RUN: begin
                // out_valid is always clear here, so capture cannot collide
                // with a consume.
                if (msm_done) begin
                    out_r_d     = msm_R;
                    out_valid_d = 1'b1;
                    full_d      = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are registered from the next state so they line up with it.
        msm_reset_d = (state_d != RUN);
        busy_d      = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            g_q         <= '0;
            x_q         <= '0;
            msm_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            g_q         <= g_d;
            x_q         <= x_d;
            msm_reset_q <= msm_reset_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_msm_loader.sv
// tb_msm_loader: directed bench for msm_loader. A behavioural core stub
// computes an order-sensitive digest of G/x a fixed number of cycles after
// its reset is released; expected digests come from the stimulus itself.
module tb_msm_loader;
    localparam int CORE_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset;

    // length = 3 instance with stub core
    msm_loader_if bus ();
    logic [2:0][511:0] G;
    logic [2:0][255:0] x;
    logic              msm_reset, busy, msm_done;
    logic [511:0]      msm_R;
    logic              auto_en, man_done, r_ovr_en;
    logic [511:0]      r_ovr;
    int                core_cnt = 0;

    // length = 1 instance, core driven by hand
    msm_loader_if bus1 ();
    logic [0:0][511:0] G1;
    logic [0:0][255:0] x1;
    logic              msm_reset1, busy1, done1;
    logic [511:0]      r1;

    int checks = 0;
    int fails  = 0;
    logic [511:0]      sb[$];
    logic [511:0]      last_r;
    logic [2:0][511:0] bp;
    logic [2:0][255:0] bs;

    function automatic logic [511:0] core_fn(input logic [2:0][511:0] g,
                                             input logic [2:0][255:0] s);
        logic [511:0] r = '0;
        for (int i = 0; i < 3; i++) r = {r[510:0], r[511]} ^ g[i] ^ {s[i], ~s[i]};
        return r;
    endfunction

    assign msm_done = (auto_en && !msm_reset && core_cnt == CORE_LAT) || man_done;
    assign msm_R    = r_ovr_en ? r_ovr : core_fn(G, x);
    always @(posedge clk) core_cnt <= msm_reset ? 0 : core_cnt + 1;

    msm_loader #(.length(3)) u_dut (
        .clk(clk), .Reset(Reset), .s(bus), .G(G), .x(x),
        .msm_reset(msm_reset), .msm_done(msm_done), .msm_R(msm_R), .busy(busy)
    );

    msm_loader #(.length(1)) u_one (
        .clk(clk), .Reset(Reset), .s(bus1), .G(G1), .x(x1),
        .msm_reset(msm_reset1), .msm_done(done1), .msm_R(r1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [511:0] p, input logic [255:0] s);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_point  = p;
        bus.in_scalar = s;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("accept_timeout", {511'b0, bus.in_ready}, 512'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_point  = {16{32'hdeadbeef}};
        bus.in_scalar = '1;
    endtask

    task automatic gen_batch();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) bp[i][j*32 +: 32] = $urandom;
            for (int j = 0; j < 8; j++)  bs[i][j*32 +: 32] = $urandom;
        end
    endtask

    task automatic load_batch(input int maxgap);
        for (int i = 0; i < 3; i++) begin
            push(bp[i], bs[i]);
            if (i < 2) tick($urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        logic [511:0] exp;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {511'b0, bus.out_valid}, 512'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        last_r = exp;
        chk({tag, "_R"}, bus.out_R, exp);
    endtask

    task automatic chk_arrays(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_G%0d", tag, i), G[i], bp[i]);
            chk($sformatf("%s_x%0d", tag, i), {256'b0, x[i]}, {256'b0, bs[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_point = '0; bus.in_scalar = '0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_point = '0; bus1.in_scalar = '0; bus1.out_ready = 1'b0;
        auto_en = 1'b1; man_done = 1'b0; r_ovr_en = 1'b0; r_ovr = '0;
        done1 = 1'b0; r1 = '0; last_r = '0;

        // Reset state
        tick(2);
        chk("rst_in_ready", {511'b0, bus.in_ready}, 512'd0);
        chk("rst_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("rst_busy", {511'b0, busy}, 512'd0);
        chk("rst_out_valid", {511'b0, bus.out_valid}, 512'd0);
        chk("rst_out_R", bus.out_R, 512'd0);
        chk("rst_G0", G[0], 512'd0);
        Reset = 1'b1;
        #1;
        chk("post_rst_in_ready", {511'b0, bus.in_ready}, 512'd1);

        // Batch 1: back-to-back, consumer always ready
        bus.out_ready = 1'b1;
        gen_batch();
        sb.push_back(core_fn(bp, bs));
        load_batch(0);
        chk("b1_kick_busy", {511'b0, busy}, 512'd1);
        chk("b1_kick_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("b1_kick_in_ready", {511'b0, bus.in_ready}, 512'd0);
        tick();
        chk("b1_run_msm_reset", {511'b0, msm_reset}, 512'd0);
        chk("b1_run_in_ready", {511'b0, bus.in_ready}, 512'd0);
        chk_arrays("b1");
        wait_result("b1");
        chk("b1_done_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("b1_done_in_ready", {511'b0, bus.in_ready}, 512'd1);
        tick();
        chk("b1_valid_pulse", {511'b0, bus.out_valid}, 512'd0);

        // Batch 2: random input gaps, result left pending
        bus.out_ready = 1'b0;
        gen_batch();
        sb.push_back(core_fn(bp, bs));
        load_batch(3);
        chk("b2_kick_in_ready", {511'b0, bus.in_ready}, 512'd0);
        tick();
        chk("b2_run_msm_reset", {511'b0, msm_reset}, 512'd0);
        chk_arrays("b2");
        wait_result("b2");

        // Batch 3 loaded while result 2 is pending
        gen_batch();
        load_batch(0);
        chk("b3_full_in_ready", {511'b0, bus.in_ready}, 512'd0);
        chk("b3_wait_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("b3_wait_busy", {511'b0, busy}, 512'd0);
        tick(2);
        chk("b3_hold_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("b3_hold_out_valid", {511'b0, bus.out_valid}, 512'd1);
        chk("b3_hold_out_R", bus.out_R, last_r);
        chk_arrays("b3");
        sb.push_back(core_fn(bp, bs));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("b3_consume_out_valid", {511'b0, bus.out_valid}, 512'd0);
        chk("b3_kick_busy", {511'b0, busy}, 512'd1);
        chk("b3_kick_msm_reset", {511'b0, msm_reset}, 512'd1);
        tick();
        chk("b3_run_msm_reset", {511'b0, msm_reset}, 512'd0);
        wait_result("b3");
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("b3_consumed", {511'b0, bus.out_valid}, 512'd0);

        // Stubbed result; Done during LOAD is ignored
        r_ovr_en = 1'b1;
        r_ovr = 512'h1234;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("load_done_out_valid", {511'b0, bus.out_valid}, 512'd0);
        chk("load_done_out_R", bus.out_R, last_r);
        auto_en = 1'b0;
        gen_batch();
        load_batch(0);
        tick();
        chk("stub_run_msm_reset", {511'b0, msm_reset}, 512'd0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("stub_out_R", bus.out_R, 512'h1234);
        chk("stub_out_valid", {511'b0, bus.out_valid}, 512'd1);
        chk("stub_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("stub_busy", {511'b0, busy}, 512'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("stub_consumed", {511'b0, bus.out_valid}, 512'd0);
        r_ovr_en = 1'b0;
        auto_en = 1'b1;

        // Reset in the middle of RUN
        gen_batch();
        load_batch(0);
        tick(2);
        chk("mid_run_msm_reset", {511'b0, msm_reset}, 512'd0);
        #2 Reset = 1'b0;
        #1;
        chk("arst_msm_reset", {511'b0, msm_reset}, 512'd1);
        chk("arst_out_valid", {511'b0, bus.out_valid}, 512'd0);
        chk("arst_busy", {511'b0, busy}, 512'd0);
        chk("arst_in_ready", {511'b0, bus.in_ready}, 512'd0);
        chk("arst_G0", G[0], 512'd0);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("arst_rel_in_ready", {511'b0, bus.in_ready}, 512'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        gen_batch();
        sb.push_back(core_fn(bp, bs));
        load_batch(1);
        chk_arrays("b5");
        wait_result("b5");
        tick();
        chk("b5_consumed", {511'b0, bus.out_valid}, 512'd0);
        bus.out_ready = 1'b0;

        // length = 1 instance
        r1 = {16{32'h0badf00d}};
        bus1.in_valid = 1'b1;
        bus1.in_point = 512'hA5A5;
        bus1.in_scalar = 256'h77;
        chk("l1_in_ready", {511'b0, bus1.in_ready}, 512'd1);
        tick();
        bus1.in_valid = 1'b0;
        chk("l1_kick_busy", {511'b0, busy1}, 512'd1);
        chk("l1_kick_in_ready", {511'b0, bus1.in_ready}, 512'd0);
        chk("l1_kick_msm_reset", {511'b0, msm_reset1}, 512'd1);
        chk("l1_G", G1[0], 512'hA5A5);
        chk("l1_x", {256'b0, x1[0]}, 512'h77);
        tick();
        chk("l1_run_msm_reset", {511'b0, msm_reset1}, 512'd0);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk("l1_out_valid", {511'b0, bus1.out_valid}, 512'd1);
        chk("l1_out_R", bus1.out_R, {16{32'h0badf00d}});
        chk("l1_done_in_ready", {511'b0, bus1.in_ready}, 512'd1);
        bus1.in_valid = 1'b1;
        bus1.in_point = 512'h5A5A;
        bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        chk("l1_same_cycle_out_valid", {511'b0, bus1.out_valid}, 512'd0);
        chk("l1_same_cycle_busy", {511'b0, busy1}, 512'd1);
        chk("l1_same_cycle_G", G1[0], 512'h5A5A);
        tick();
        chk("l1_same_cycle_run", {511'b0, msm_reset1}, 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
